// File: rtl/ssa_pkg.sv
// Shared SSA datapath parameters (also used by the split stage), accumulator
// width helper and the recombine FSM state type.
package ssa_pkg;

  localparam int PIECE_W_DEF  = 2;
  localparam int COEF_W_DEF   = 12;
  localparam int NUM_COEF_DEF = 7;
  localparam int OUT_W_DEF    = 16;

  function automatic int acc_w(input int piece_w, input int coef_w, input int num_coef);
    return coef_w + piece_w * (num_coef - 1);
  endfunction

  localparam int ACC_W_DEF = acc_w(PIECE_W_DEF, COEF_W_DEF, NUM_COEF_DEF);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } ssa_state_e;

endpackage

// File: rtl/ssa_coef_acc.sv
// Shift-and-add datapath: adds each accepted coefficient at offset PIECE_W*idx.
// sum_next is the accumulator value including the coefficient currently offered.
module ssa_coef_acc
  import ssa_pkg::*;
#(
  parameter int PIECE_W  = PIECE_W_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int SUM_W    = ACC_W_DEF + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_en,
  input  logic              clear,
  input  logic [COEF_W-1:0] coef,
  output logic              last,
  output logic [SUM_W-1:0]  sum_next
);

  localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] coef_ext;

  assign coef_ext = SUM_W'(coef);
  assign sum_next = acc_q + (coef_ext << (PIECE_W * int'(idx_q)));
  assign last     = (idx_q == IDX_W'(NUM_COEF - 1));

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (clear) begin
      acc_d = '0;
      idx_d = '0;
    end else if (add_en) begin
      acc_d = sum_next;
      idx_d = last ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/ssa_recombine.sv
// SSA recombination: folds NUM_COEF coefficient lanes back into one integer.
// Optional overflow flag enabled by defining SSA_RECOMBINE_OVF_EN.
//
//   state | meaning
//   ACCUM | accepting coefficients, in_ready high
//   DONE  | product presented on out_*, waiting for out_ready
module ssa_recombine
  import ssa_pkg::*;
#(
  parameter int PIECE_W  = PIECE_W_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf
);

`ifdef SSA_RECOMBINE_OVF_EN
  // One guard bit above ACC_W keeps the carry of the final add for the flag.
  localparam int SUM_W = acc_w(PIECE_W, COEF_W, NUM_COEF) + 1;
`else
  localparam int SUM_W = OUT_W;
`endif

  ssa_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
`ifdef SSA_RECOMBINE_OVF_EN
  logic             out_ovf_q, out_ovf_d;
`endif

  logic             accept;
  logic             handshake;
  logic             last;
  logic [SUM_W-1:0] sum_next;

  assign accept    = in_valid & in_ready_q;
  assign handshake = out_valid_q & out_ready;

  ssa_coef_acc #(
    .PIECE_W  (PIECE_W),
    .COEF_W   (COEF_W),
    .NUM_COEF (NUM_COEF),
    .SUM_W    (SUM_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .add_en   (accept),
    .clear    (handshake),
    .coef     (in_coef),
    .last     (last),
    .sum_next (sum_next)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef SSA_RECOMBINE_OVF_EN
    out_ovf_d   = out_ovf_q;
`endif
    case (state_q)
      ACCUM: begin
        in_ready_d = 1'b1;
        if (accept && last) begin
          state_d     = DONE;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = sum_next[OUT_W-1:0];
`ifdef SSA_RECOMBINE_OVF_EN
          out_ovf_d   = |sum_next[SUM_W-1:OUT_W];
`endif
        end
      end
      DONE: begin
        if (handshake) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SSA_RECOMBINE_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SSA_RECOMBINE_OVF_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef SSA_RECOMBINE_OVF_EN
  assign out_ovf   = out_ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_ssa_recombine.sv
// Scoreboard bench for ssa_recombine: reference sum computed arithmetically
// from the coefficient list, checked by an independent output monitor.
module tb_ssa_recombine;

  localparam int PW = 2;
  localparam int CW = 12;
  localparam int NC = 7;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_coef = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_ovf;

  ssa_recombine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          hold = 1'b0;
  bit          rand_rdy = 1'b0;
  int          gap_pct = 0;
  int unsigned f[NC];
  exp_t        last_exp;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned c[NC]);
    exp_t   e;
    longint s = 0;
    longint w = 1;
    for (int i = 0; i < NC; i++) begin
      s += longint'(c[i]) * w;
      w *= (2 ** PW);
    end
    e.data = OW'(s % (64'd1 << OW));
`ifdef SSA_RECOMBINE_OVF_EN
    e.ovf = (s >= (64'd1 << OW));
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Consumer side: out_ready pattern.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: pops one expectation per completed output handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last word (or abort point).
  task automatic send_frame(input int unsigned c[NC], input int abort_after);
    int n = 0;
    int budget = 1000;
    bit rdy;
    while (n < NC) begin
      if (abort_after >= 0 && n == abort_after) begin
        in_valid = 1'b0;
        return;
      end
      if (budget == 0) begin
        check("frame_timeout", n, NC);
        break;
      end
      budget--;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_coef  = CW'($urandom);
        @(posedge clk);
        #1;
        continue;
      end
      in_valid = 1'b1;
      in_coef  = CW'(c[n]);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        n++;
        if (n == NC) begin
          last_exp = model(c);
          sb.push_back(last_exp);
          check("out_valid_latency", out_valid, 1);
        end else begin
          check("no_early_out_valid", out_valid, 0);
        end
      end
    end
    in_valid = 1'b0;
    in_coef  = CW'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    f = '{9, 18, 27, 36, 27, 18, 9};
    send_frame(f, -1);
    check("ffxff_data", out_data, 16'hFE01);
    check("ffxff_ovf", out_ovf, 0);
    wait_drain();

    f = '{0, 0, 0, 0, 0, 0, 0};
    send_frame(f, -1);
    check("zero_data", out_data, 16'h0000);
    wait_drain();

    f = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    send_frame(f, -1);
    check("allfff_data", out_data, 16'h3AAB);
`ifdef SSA_RECOMBINE_OVF_EN
    check("allfff_ovf", out_ovf, 1);
`else
    check("allfff_ovf", out_ovf, 0);
`endif
    wait_drain();

    // Backpressure: hold the result, offer extra words that must be ignored.
    hold = 1'b1;
    f = '{5, 300, 7, 4000, 1, 2, 3};
    send_frame(f, -1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_coef  = CW'($urandom);
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_data", out_data, last_exp.data);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    wait_drain();
    f = '{1, 0, 0, 0, 0, 0, 0};
    send_frame(f, -1);
    check("after_hold_data", out_data, 16'h0001);
    wait_drain();

    gap_pct = 40;
    f = '{1, 1, 1, 1, 1, 1, 1};
    send_frame(f, -1);
    check("gaps_data", out_data, 16'h1555);
    wait_drain();
    gap_pct = 0;

    // Mid-frame reset discards the partial sum.
    f = '{11, 22, 33, 44, 55, 66, 77};
    send_frame(f, 3);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    f = '{2, 0, 0, 0, 0, 0, 0};
    send_frame(f, -1);
    check("after_rst_data", out_data, 16'h0002);
    wait_drain();

    rand_rdy = 1'b1;
    gap_pct  = 25;
    for (int fr = 0; fr < 20; fr++) begin
      for (int i = 0; i < NC; i++) f[i] = $urandom_range(0, (1 << CW) - 1);
      send_frame(f, -1);
    end
    wait_drain();
    rand_rdy = 1'b0;
    gap_pct  = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
